cont_s_updown_mod: RTL and testbench
====================================

Name: cont_s_updown_mod

Overview:
Synchronous, parametrised modulo-N up/down counter.
- Successor to the fixed 4-bit ripple decade down-counter.
- Generalised in width and modulus, with run-time direction, parallel load, enable and cascade outputs.
- Used as the counting element for timers and multi-digit (BCD) chains.
- All state changes occur on the single clock edge; no ripple clocking.

Parameters:
WIDTH, 4, counter register width in bits
MODULUS, 10, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH
RESET_VALUE, 0, value taken on clear; must be < MODULUS

Ports:
clock  input  1  single clock; all flops update on posedge
clear  input  1  reset, synchronous, active-low (0 = reset on next posedge)
enable  input  1  count enable; 1 = advance one step this cycle
up  input  1  direction; 1 = increment, 0 = decrement
load  input  1  parallel load strobe
load_value  input  WIDTH  value to load
result  output  WIDTH  registered count
terminal  output  1  combinational: count is at the end of range for the current direction
carry_out  output  1  combinational cascade enable for the next stage
wrapped  output  1  registered one-cycle pulse: counter wrapped on the previous edge
load_error  output  1  registered one-cycle pulse: last load was out of range and was clamped

Behaviour:
- Reset (clear==0 at posedge):
  - result=RESET_VALUE, wrapped=0, load_error=0.
  - Overrides load and enable.
- Priority at each posedge: clear > load > enable > hold.
- Load (load==1):
  - If load_value < MODULUS: result<=load_value, load_error<=0.
  - Otherwise: result<=MODULUS-1, load_error<=1.
  - wrapped<=0 in both cases.
  - enable is ignored in a load cycle.
- Count (enable==1, load==0):
  - up=1: result==MODULUS-1 -> 0 with wrapped<=1; otherwise result+1.
  - up=0: result==0 -> MODULUS-1 with wrapped<=1; otherwise result-1.
  - Latency: new value is visible one cycle after the enabling edge.
- Hold (enable==0, load==0): result is unchanged; wrapped<=0; load_error<=0.
- terminal = up ? (result==MODULUS-1) : (result==0). It follows direction changes combinationally.
- carry_out = enable & terminal & ~load & clear.
  - Asserted exactly in the cycle whose edge wraps the counter.
  - Chain stage k+1 enable = stage k carry_out.
- Direction change mid-count takes effect on the same edge; there is no reversal penalty cycle.
- When MODULUS == 2**WIDTH, wrap is the natural overflow. The comparison logic must still be correct, with no extra-bit truncation errors.
- Out-of-range result is unreachable after reset. If forced, the next count step goes to 0 (up) or MODULUS-1 (down).
- Power-up before the first clear: result is undefined. The bench must apply clear first.
- Illegal parameters (MODULUS<2, MODULUS>2**WIDTH, RESET_VALUE>=MODULUS) cause an elaboration-time error.

Decomposition:
- Shared package cont_pkg holds:
  - localparam helper for the width of MODULUS-1;
  - direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0;
  - the BCD preset WIDTH=4 / MODULUS=10.
- One sub-module, cont_next_val: combinational next-value / wrap-detect from (result, up).
  - It keeps the register process trivial and is reused by chained stages.
- Top level holds the registers and the priority mux.

Test Plan:
- Reset: hold clear=0 for 2 edges with enable=1 -> result=0, wrapped=0, load_error=0; release -> counting starts on the next edge.
- Decade up-wrap: WIDTH=4, MODULUS=10, up=1, enable=1 for 12 edges from 0 -> result 1..9,0,1,2; carry_out=1 only while result=9; wrapped=1 in the cycle after 9->0.
- Decade down-wrap: up=0 from 0 -> result 9,8,...,0,9; terminal=1 at 0; flip up=1 at result=5 -> next value 6.
- Load: load_value=7 -> result=7, load_error=0; load_value=12 -> result=9, load_error=1 for one cycle; load together with enable=1 -> loaded value wins.
- Full-range: WIDTH=3, MODULUS=8, up=1 from 6 -> 7,0 with wrapped=1; down from 0 -> 7.
- Cascade: two instances (units, tens), tens.enable = units.carry_out, 100 enabled edges up from 00 -> 00; tens wraps exactly once; mid-run clear=0 -> both stages reset to 0 on that edge.

Source files
------------

// File: rtl/cont_pkg.sv
// Shared definitions for the modulo-N up/down counter family.
//   DIR_UP / DIR_DOWN : encoding of the run-time direction input
//   BCD_WIDTH / BCD_MODULUS : preset for one decimal digit
//   cnt_width() : bits needed to hold MODULUS-1
package cont_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int BCD_WIDTH   = 4;
  localparam int BCD_MODULUS = 10;

  // Width of the largest count value (MODULUS-1), at least one bit.
  function automatic int cnt_width(input int modulus);
    if (modulus <= 2) return 1;
    return $clog2(modulus);
  endfunction

endpackage

// File: rtl/cont_next_val.sv
// Combinational step logic for one counter stage.
//   result_i   : current count
//   up_i       : direction (DIR_UP / DIR_DOWN)
//   next_o     : value after one enabled step
//   terminal_o : count sits at the end of range for the current direction
module cont_next_val
  import cont_pkg::*;
#(
  parameter int WIDTH   = BCD_WIDTH,
  parameter int MODULUS = BCD_MODULUS
) (
  input  logic [WIDTH-1:0] result_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] next_o,
  output logic             terminal_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  always_comb begin
    next_o     = result_i;
    terminal_o = 1'b0;
    if (up_i == DIR_UP) begin
      terminal_o = (result_i == MAX_VAL);
      // >= also recovers a forced out-of-range value back to 0
      if (result_i >= MAX_VAL) next_o = '0;
      else                     next_o = result_i + ONE;
    end else begin
      terminal_o = (result_i == '0);
      if (result_i == '0 || result_i > MAX_VAL) next_o = MAX_VAL;
      else                                      next_o = result_i - ONE;
    end
  end

endmodule

// File: rtl/cont_s_updown_mod.sv
// Synchronous modulo-N up/down counter with load, enable and cascade outputs.
//   clock      : single clock, posedge
//   clear      : synchronous active-low reset
//   enable     : advance one step this cycle
//   up         : 1 = increment, 0 = decrement
//   load       : parallel load strobe (beats enable)
//   load_value : value to load, clamped to MODULUS-1 when out of range
//   result     : registered count
//   terminal   : count at end of range for current direction
//   carry_out  : enable for the next cascaded stage
//   wrapped    : pulse, counter wrapped on the previous edge
//   load_error : pulse, previous load was clamped
module cont_s_updown_mod
  import cont_pkg::*;
#(
  parameter int WIDTH       = BCD_WIDTH,
  parameter int MODULUS     = BCD_MODULUS,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] result,
  output logic             terminal,
  output logic             carry_out,
  output logic             wrapped,
  output logic             load_error
);

  if (MODULUS < 2) begin : g_bad_mod_low
    $error("cont_s_updown_mod: MODULUS must be at least 2");
  end
  // Compared through the bit width so large WIDTH values cannot overflow 2**WIDTH
  if (cnt_width(MODULUS) > WIDTH) begin : g_bad_mod_high
    $error("cont_s_updown_mod: MODULUS exceeds 2**WIDTH");
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_rst
    $error("cont_s_updown_mod: RESET_VALUE must be below MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
  // One extra bit so MODULUS == 2**WIDTH is representable in the range check
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] result_q, result_d;
  logic             wrapped_q, wrapped_d;
  logic             load_error_q, load_error_d;
  logic [WIDTH-1:0] step_val;
  logic             step_term;
  logic             load_ok;

  cont_next_val #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .result_i   (result_q),
    .up_i       (up),
    .next_o     (step_val),
    .terminal_o (step_term)
  );

  assign load_ok = ({1'b0, load_value} < MOD_EXT);

  always_comb begin
    result_d     = result_q;
    wrapped_d    = 1'b0;
    load_error_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        result_d = load_value;
      end else begin
        result_d     = MAX_VAL;
        load_error_d = 1'b1;
      end
    end else if (enable) begin
      result_d  = step_val;
      wrapped_d = step_term;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      result_q     <= RST_VAL;
      wrapped_q    <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      result_q     <= result_d;
      wrapped_q    <= wrapped_d;
      load_error_q <= load_error_d;
    end
  end

  assign result     = result_q;
  assign terminal   = step_term;
  assign carry_out  = enable & step_term & ~load & clear;
  assign wrapped    = wrapped_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_cont_s_updown_mod.sv
module tb_cont_s_updown_mod;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  // decade instance
  logic       clear = 1'b0, enable = 1'b0, up = 1'b1, load = 1'b0;
  logic [3:0] load_value = '0;
  logic [3:0] result;
  logic       terminal, carry_out, wrapped, load_error;

  // full-range instance (WIDTH=3, MODULUS=8)
  logic       c8_clear = 1'b0, c8_enable = 1'b0, c8_up = 1'b1, c8_load = 1'b0;
  logic [2:0] c8_load_value = '0;
  logic [2:0] c8_result;
  logic       c8_terminal, c8_carry, c8_wrapped, c8_load_error;

  // two-digit cascade
  logic       cc_clear = 1'b0, cc_en = 1'b0;
  logic [3:0] u_res, t_res;
  logic       u_term, t_term, u_carry, t_carry, u_wrap, t_wrap, u_lerr, t_lerr;

  int compared   = 0;
  int mismatched = 0;

  cont_s_updown_mod #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut (
    .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .result(result), .terminal(terminal),
    .carry_out(carry_out), .wrapped(wrapped), .load_error(load_error));

  cont_s_updown_mod #(.WIDTH(3), .MODULUS(8), .RESET_VALUE(0)) dut8 (
    .clock(clock), .clear(c8_clear), .enable(c8_enable), .up(c8_up), .load(c8_load),
    .load_value(c8_load_value), .result(c8_result), .terminal(c8_terminal),
    .carry_out(c8_carry), .wrapped(c8_wrapped), .load_error(c8_load_error));

  cont_s_updown_mod #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) units (
    .clock(clock), .clear(cc_clear), .enable(cc_en), .up(1'b1), .load(1'b0),
    .load_value(4'd0), .result(u_res), .terminal(u_term),
    .carry_out(u_carry), .wrapped(u_wrap), .load_error(u_lerr));

  cont_s_updown_mod #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) tens (
    .clock(clock), .clear(cc_clear), .enable(u_carry), .up(1'b1), .load(1'b0),
    .load_value(4'd0), .result(t_res), .terminal(t_term),
    .carry_out(t_carry), .wrapped(t_wrap), .load_error(t_lerr));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0; enable = 1'b1; up = 1'b1; load = 1'b0;
    step();
    load = 1'b1; load_value = 4'd7;
    step();
    load = 1'b0;
    compared++;
    if (result !== 4'd0) begin mismatched++; $display("FAIL reset_result got=%0d exp=0", result); end
    compared++;
    if (wrapped !== 1'b0) begin mismatched++; $display("FAIL reset_wrapped got=%b exp=0", wrapped); end
    compared++;
    if (load_error !== 1'b0) begin mismatched++; $display("FAIL reset_load_error got=%b exp=0", load_error); end
    #1;
    compared++;
    if (carry_out !== 1'b0) begin mismatched++; $display("FAIL reset_carry got=%b exp=0", carry_out); end
    clear = 1'b1;
    step();
    compared++;
    if (result !== 4'd1) begin mismatched++; $display("FAIL reset_release got=%0d exp=1", result); end
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_res [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic [3:0] prev;
    clear = 1'b0; step(); clear = 1'b1;
    enable = 1'b1; up = 1'b1;
    prev = 4'd0;
    for (int i = 0; i < 12; i++) begin
      #1;
      compared++;
      if (carry_out !== (prev == 4'd9)) begin
        mismatched++; $display("FAIL up_carry[%0d] got=%b exp=%b", i, carry_out, (prev == 4'd9));
      end
      step();
      compared++;
      if (result !== exp_res[i]) begin
        mismatched++; $display("FAIL up_result[%0d] got=%0d exp=%0d", i, result, exp_res[i]);
      end
      compared++;
      if (wrapped !== (prev == 4'd9)) begin
        mismatched++; $display("FAIL up_wrapped[%0d] got=%b exp=%b", i, wrapped, (prev == 4'd9));
      end
      prev = exp_res[i];
    end
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_res [11] = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9};
    enable = 1'b0;
    clear = 1'b0; step(); clear = 1'b1;
    up = 1'b0;
    #1;
    compared++;
    if (terminal !== 1'b1) begin mismatched++; $display("FAIL down_terminal_at0 got=%b exp=1", terminal); end
    up = 1'b1;
    #1;
    compared++;
    if (terminal !== 1'b0) begin mismatched++; $display("FAIL dir_flip_terminal got=%b exp=0", terminal); end
    up = 1'b0; enable = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      compared++;
      if (result !== exp_res[i]) begin
        mismatched++; $display("FAIL down_result[%0d] got=%0d exp=%0d", i, result, exp_res[i]);
      end
      compared++;
      if (terminal !== (exp_res[i] == 4'd0)) begin
        mismatched++; $display("FAIL down_terminal[%0d] got=%b exp=%b", i, terminal, (exp_res[i] == 4'd0));
      end
    end
    compared++;
    if (wrapped !== 1'b1) begin mismatched++; $display("FAIL down_wrapped got=%b exp=1", wrapped); end
    // 9 -> 8 -> 7 -> 6 -> 5, then reverse
    for (int i = 0; i < 4; i++) step();
    compared++;
    if (result !== 4'd5) begin mismatched++; $display("FAIL down_to5 got=%0d exp=5", result); end
    up = 1'b1;
    step();
    compared++;
    if (result !== 4'd6) begin mismatched++; $display("FAIL reverse_step got=%0d exp=6", result); end
    enable = 1'b0;
  endtask

  task automatic test_load();
    enable = 1'b0; up = 1'b1;
    load = 1'b1; load_value = 4'd7;
    step();
    compared++;
    if (result !== 4'd7) begin mismatched++; $display("FAIL load7_result got=%0d exp=7", result); end
    compared++;
    if (load_error !== 1'b0) begin mismatched++; $display("FAIL load7_error got=%b exp=0", load_error); end
    load_value = 4'd12;
    step();
    compared++;
    if (result !== 4'd9) begin mismatched++; $display("FAIL load12_clamp got=%0d exp=9", result); end
    compared++;
    if (load_error !== 1'b1) begin mismatched++; $display("FAIL load12_error got=%b exp=1", load_error); end
    load = 1'b0;
    step();
    compared++;
    if (load_error !== 1'b0) begin mismatched++; $display("FAIL load_error_pulse got=%b exp=0", load_error); end
    compared++;
    if (result !== 4'd9) begin mismatched++; $display("FAIL hold_result got=%0d exp=9", result); end
    // at 9 going up, a simultaneous load must suppress the cascade carry
    load = 1'b1; enable = 1'b1; load_value = 4'd3;
    #1;
    compared++;
    if (carry_out !== 1'b0) begin mismatched++; $display("FAIL load_blocks_carry got=%b exp=0", carry_out); end
    step();
    compared++;
    if (result !== 4'd3) begin mismatched++; $display("FAIL load_beats_enable got=%0d exp=3", result); end
    compared++;
    if (wrapped !== 1'b0) begin mismatched++; $display("FAIL load_wrapped got=%b exp=0", wrapped); end
    load = 1'b0; enable = 1'b0;
  endtask

  task automatic test_full_range();
    c8_clear = 1'b0; step(); c8_clear = 1'b1;
    c8_load = 1'b1; c8_load_value = 3'd6;
    step();
    c8_load = 1'b0; c8_enable = 1'b1; c8_up = 1'b1;
    step();
    compared++;
    if (c8_result !== 3'd7) begin mismatched++; $display("FAIL fr_up7 got=%0d exp=7", c8_result); end
    compared++;
    if (c8_terminal !== 1'b1) begin mismatched++; $display("FAIL fr_term7 got=%b exp=1", c8_terminal); end
    step();
    compared++;
    if (c8_result !== 3'd0) begin mismatched++; $display("FAIL fr_wrap0 got=%0d exp=0", c8_result); end
    compared++;
    if (c8_wrapped !== 1'b1) begin mismatched++; $display("FAIL fr_wrapped_up got=%b exp=1", c8_wrapped); end
    c8_up = 1'b0;
    step();
    compared++;
    if (c8_result !== 3'd7) begin mismatched++; $display("FAIL fr_down7 got=%0d exp=7", c8_result); end
    compared++;
    if (c8_wrapped !== 1'b1) begin mismatched++; $display("FAIL fr_wrapped_down got=%b exp=1", c8_wrapped); end
    c8_enable = 1'b0; c8_load = 1'b1; c8_load_value = 3'd7;
    step();
    c8_load = 1'b0;
    compared++;
    if (c8_load_error !== 1'b0) begin mismatched++; $display("FAIL fr_load7_error got=%b exp=0", c8_load_error); end
  endtask

  task automatic test_cascade();
    int tens_wraps = 0;
    cc_clear = 1'b0; cc_en = 1'b1;
    step();
    cc_clear = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (t_wrap === 1'b1) tens_wraps++;
      if (i == 55) begin
        compared++;
        if ({t_res, u_res} !== {4'd5, 4'd5}) begin
          mismatched++; $display("FAIL cascade_55 got=%0d%0d exp=55", t_res, u_res);
        end
      end
    end
    compared++;
    if ({t_res, u_res} !== 8'h00) begin mismatched++; $display("FAIL cascade_100 got=%0d%0d exp=00", t_res, u_res); end
    compared++;
    if (tens_wraps != 1) begin mismatched++; $display("FAIL cascade_tens_wraps got=%0d exp=1", tens_wraps); end
    for (int i = 0; i < 23; i++) step();
    compared++;
    if ({t_res, u_res} !== {4'd2, 4'd3}) begin mismatched++; $display("FAIL cascade_23 got=%0d%0d exp=23", t_res, u_res); end
    cc_clear = 1'b0;
    step();
    compared++;
    if ({t_res, u_res} !== 8'h00) begin mismatched++; $display("FAIL cascade_clear got=%0d%0d exp=00", t_res, u_res); end
    cc_clear = 1'b1; cc_en = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_full_range();
    test_cascade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
